// File: rtl/ai_switch_pkg.sv
// ai_switch_pkg: register map, ID value and field widths shared by the management block.
package ai_switch_pkg;
    localparam logic [7:0]  REG_ID         = 8'h00;
    localparam logic [7:0]  REG_CTRL       = 8'h04;
    localparam logic [7:0]  REG_QOS_BASE   = 8'h20;
    localparam logic [7:0]  REG_ROUTE_BASE = 8'h40;
    localparam logic [7:0]  REG_FWD_BASE   = 8'h80;
    localparam logic [7:0]  REG_DROP_BASE  = 8'hA0;
    localparam logic [31:0] ID_VALUE       = 32'h4149_0001;
    localparam int          QOS_W          = 4;
endpackage

// File: rtl/ai_sat_counter.sv
// ai_sat_counter: 32-bit event counter that sticks at all-ones; clear beats increment.
module ai_sat_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 32'd1;
    end
endmodule

// File: rtl/ai_switch_mgmt_regs.sv
// ai_switch_mgmt_regs: management-bus responder owning switch configuration and per-port telemetry.
module ai_switch_mgmt_regs
    import ai_switch_pkg::*;
#(
    parameter int N_PORTS  = 4,
    parameter int N_ROUTES = 16,
    parameter int PORT_W   = $clog2(N_PORTS)
) (
    input  logic                         mgmt_clk,
    input  logic                         mgmt_rst,
    input  logic                         mgmt_sel,
    input  logic [7:0]                   mgmt_addr,
    input  logic [31:0]                  mgmt_wdata,
    input  logic                         mgmt_write,
    output logic [31:0]                  mgmt_rdata,
    output logic                         mgmt_err,
    output logic                         cfg_enable,
    output logic [N_ROUTES*PORT_W-1:0]   cfg_route,
    output logic [N_PORTS*QOS_W-1:0]     cfg_qos,
    input  logic [N_PORTS-1:0]           stat_fwd_pulse,
    input  logic [N_PORTS-1:0]           stat_drop_pulse
);
    localparam int ROUTE_W = $clog2(N_ROUTES);
    logic [5:0] word, off_q, off_r, off_f, off_d;
    logic hit_id, hit_ctrl, hit_q, hit_r, hit_f, hit_d, hit, wr, clr_all;
    logic [31:0] rd;
    logic [QOS_W-1:0] qos [N_PORTS];
    logic [PORT_W-1:0] route [N_ROUTES];
    logic [31:0] fwd_cnt [N_PORTS];
    logic [31:0] drop_cnt [N_PORTS];

    // Offsets wrap below their base, so a single upper-bound compare decodes each window.
    assign word     = mgmt_addr[7:2];
    assign off_q    = word - REG_QOS_BASE[7:2];
    assign off_r    = word - REG_ROUTE_BASE[7:2];
    assign off_f    = word - REG_FWD_BASE[7:2];
    assign off_d    = word - REG_DROP_BASE[7:2];
    assign hit_id   = word == REG_ID[7:2];
    assign hit_ctrl = word == REG_CTRL[7:2];
    assign hit_q    = off_q < 6'(N_PORTS);
    assign hit_r    = off_r < 6'(N_ROUTES);
    assign hit_f    = off_f < 6'(N_PORTS);
    assign hit_d    = off_d < 6'(N_PORTS);
    assign hit      = hit_id | hit_ctrl | hit_q | hit_r | hit_f | hit_d;
    assign wr       = mgmt_sel & mgmt_write;
    assign clr_all  = wr & hit_ctrl & mgmt_wdata[1];

    assign rd = hit_id   ? ID_VALUE :
                hit_ctrl ? {31'b0, cfg_enable} :
                hit_q    ? {{(32-QOS_W){1'b0}}, qos[off_q[PORT_W-1:0]]} :
                hit_r    ? {{(32-PORT_W){1'b0}}, route[off_r[ROUTE_W-1:0]]} :
                hit_f    ? fwd_cnt[off_f[PORT_W-1:0]] :
                hit_d    ? drop_cnt[off_d[PORT_W-1:0]] : '0;

    always_ff @(posedge mgmt_clk) begin
        if (mgmt_rst) begin
            mgmt_rdata <= '0;
            mgmt_err   <= 1'b0;
            cfg_enable <= 1'b0;
            for (int p = 0; p < N_PORTS; p++) qos[p] <= QOS_W'(1);
            for (int i = 0; i < N_ROUTES; i++) route[i] <= PORT_W'(i % N_PORTS);
        end else begin
            mgmt_err <= mgmt_sel & ~hit;
            if (mgmt_sel & ~mgmt_write) mgmt_rdata <= rd;
            if (wr & hit_ctrl) cfg_enable <= mgmt_wdata[0];
            if (wr & hit_q)
                qos[off_q[PORT_W-1:0]] <= (mgmt_wdata[QOS_W-1:0] == '0) ? QOS_W'(1) : mgmt_wdata[QOS_W-1:0];
            if (wr & hit_r) route[off_r[ROUTE_W-1:0]] <= mgmt_wdata[PORT_W-1:0];
        end
    end

    for (genvar i = 0; i < N_ROUTES; i++) begin : g_route
        assign cfg_route[i*PORT_W +: PORT_W] = route[i];
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt
        assign cfg_qos[p*QOS_W +: QOS_W] = qos[p];
        ai_sat_counter u_fwd (
            .clk(mgmt_clk), .rst(mgmt_rst), .inc(stat_fwd_pulse[p]), .clr(clr_all), .cnt(fwd_cnt[p])
        );
        ai_sat_counter u_drop (
            .clk(mgmt_clk), .rst(mgmt_rst), .inc(stat_drop_pulse[p]), .clr(clr_all), .cnt(drop_cnt[p])
        );
    end
endmodule

// File: tb/tb_ai_switch_mgmt_regs.sv
// tb_ai_switch_mgmt_regs: directed and randomized checks of the management register block against a register-map model.
module tb_ai_switch_mgmt_regs;
    logic clk = 1'b0, rst = 1'b1, sel = 1'b0, write = 1'b0;
    logic [7:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0] fwd = '0, drop = '0;
    logic [31:0] rdata, route;
    logic err, en;
    logic [15:0] qos;
    int n_tests = 0, n_fail = 0;
    bit started = 0;
    bit m_en, m_err;
    int m_qos [4];
    int m_route [16];
    logic [31:0] m_fwd [4], m_drop [4], m_rdata;

    ai_switch_mgmt_regs dut (
        .mgmt_clk(clk), .mgmt_rst(rst), .mgmt_sel(sel), .mgmt_addr(addr), .mgmt_wdata(wdata),
        .mgmt_write(write), .mgmt_rdata(rdata), .mgmt_err(err), .cfg_enable(en), .cfg_route(route),
        .cfg_qos(qos), .stat_fwd_pulse(fwd), .stat_drop_pulse(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [7:0] a, output bit ok);
        int w = int'(a) / 4;
        ok = 1;
        if (w == 0) return 32'h4149_0001;
        if (w == 1) return {31'b0, m_en};
        if (w >= 8 && w < 12) return 32'(m_qos[w-8]);
        if (w >= 16 && w < 32) return 32'(m_route[w-16]);
        if (w >= 32 && w < 36) return m_fwd[w-32];
        if (w >= 40 && w < 44) return m_drop[w-40];
        ok = 0;
        return 0;
    endfunction

    function automatic logic [31:0] exp_route();
        logic [31:0] v = '0;
        for (int i = 0; i < 16; i++) v = v | (32'(m_route[i]) << (2*i));
        return v;
    endfunction

    function automatic logic [31:0] exp_qos();
        logic [31:0] v = '0;
        for (int p = 0; p < 4; p++) v = v | (32'(m_qos[p]) << (4*p));
        return v;
    endfunction

    // Reference model: the register map as plain arrays, updated once per edge.
    always @(posedge clk) begin
        bit ok;
        logic [31:0] rv;
        int w;
        if (rst) begin
            m_rdata = 0; m_err = 0; m_en = 0; started = 1;
            for (int p = 0; p < 4; p++) begin m_qos[p] = 1; m_fwd[p] = 0; m_drop[p] = 0; end
            for (int i = 0; i < 16; i++) m_route[i] = i % 4;
        end else begin
            rv = mread(addr, ok);
            m_err = sel && !ok;
            if (sel && !write) m_rdata = rv;
            for (int p = 0; p < 4; p++) begin
                if (fwd[p] && m_fwd[p] != 32'hFFFF_FFFF) m_fwd[p] = m_fwd[p] + 1;
                if (drop[p] && m_drop[p] != 32'hFFFF_FFFF) m_drop[p] = m_drop[p] + 1;
            end
            if (sel && write && ok) begin
                w = int'(addr) / 4;
                if (w == 1) begin
                    m_en = wdata[0];
                    if (wdata[1]) for (int p = 0; p < 4; p++) begin m_fwd[p] = 0; m_drop[p] = 0; end
                end else if (w >= 8 && w < 12) m_qos[w-8] = (wdata[3:0] == 0) ? 1 : int'(wdata[3:0]);
                else if (w >= 16 && w < 32) m_route[w-16] = int'(wdata % 4);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("rdata", rdata, m_rdata);
            check("err", 32'(err), 32'(m_err));
            check("enable", 32'(en), 32'(m_en));
            check("qos", 32'(qos), exp_qos());
            check("route", route, exp_route());
        end
    end

    task automatic drive(input logic s, input logic w, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] f, input logic [3:0] dr);
        @(negedge clk);
        sel = s; write = w; addr = a; wdata = d; fwd = f; drop = dr;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] a;
        logic [31:0] d;
        repeat (3) idle();
        rst = 1'b0;
        check("rst_enable", 32'(en), 0);
        check("rst_qos", 32'(qos), 32'h1111);
        check("rst_route5", 32'(route[11:10]), 1);
        drive(1, 0, 8'h00, 0, 0, 0); idle();
        check("id_read", rdata, 32'h4149_0001);
        check("id_model", m_rdata, 32'h4149_0001);
        drive(1, 1, 8'h44, 32'hFFFF_FFFF, 0, 0); drive(1, 0, 8'h44, 0, 0, 0); idle();
        check("route1_read", rdata, 3);
        check("route1_cfg", 32'(route[3:2]), 3);
        drive(1, 1, 8'h28, 0, 0, 0); drive(1, 0, 8'h28, 0, 0, 0); idle();
        check("qos2_zero", rdata, 1);
        check("qos2_cfg", 32'(qos[11:8]), 1);
        drive(0, 0, 8'h00, 0, 4'b0010, 4'b0010);
        repeat (4) drive(0, 0, 8'h00, 0, 4'b0010, 0);
        drive(1, 0, 8'h84, 0, 0, 0); idle();
        check("fwd1_cnt", rdata, 5);
        check("fwd1_model", m_fwd[1], 5);
        drive(1, 0, 8'hA4, 0, 0, 0); idle();
        check("drop1_cnt", rdata, 1);
        drive(1, 1, 8'h04, 3, 4'b0010, 0); drive(1, 0, 8'h84, 0, 0, 0); idle();
        check("clear_wins", rdata, 0);
        check("ctrl_enable", 32'(en), 1);
        drive(1, 0, 8'h04, 0, 0, 0); idle();
        check("ctrl_read", rdata, 1);
        force dut.g_cnt[0].u_fwd.cnt = 32'hFFFF_FFFE;
        m_fwd[0] = 32'hFFFF_FFFE;
        idle();
        release dut.g_cnt[0].u_fwd.cnt;
        repeat (3) drive(0, 0, 8'h00, 0, 4'b0001, 0);
        drive(1, 0, 8'h80, 0, 0, 0); idle();
        check("fwd0_saturate", rdata, 32'hFFFF_FFFF);
        drive(1, 0, 8'h90, 0, 0, 0); idle();
        check("unmapped_rdata", rdata, 0);
        check("unmapped_err", 32'(err), 1);
        idle();
        check("err_one_cycle", 32'(err), 0);
        drive(1, 1, 8'h80, 32'h1234, 0, 0); idle();
        check("ro_write_err", 32'(err), 0);
        drive(1, 0, 8'h80, 0, 0, 0); idle();
        check("ro_write_ignored", rdata, 32'hFFFF_FFFF);
        drive(1, 1, 8'h40, 2, 0, 0); idle();
        check("route0_written", 32'(route[1:0]), 2);
        drive(1, 1, 8'h40, 3, 0, 0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        check("rst_route0", 32'(route[1:0]), 0);
        check("rst_rdata", rdata, 0);
        check("rst_enable2", 32'(en), 0);
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) :
                8'({$urandom_range(0, 1) ? 6'($urandom_range(0, 11)) : 6'($urandom_range(16, 44)), 2'($urandom)});
            d = $urandom;
            if (a[7:2] == 6'd1 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, 4'($urandom), 4'($urandom));
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        repeat (2) idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
